// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with shared prescaler/period counter and per-channel shadowed duties.
// Define PWM_RAMP_EN to make active duties slew toward their shadows by at most RAMP_STEP per period.
module pwm_multi #(
    parameter int CH        = 4,
    parameter int CW        = 12,
    parameter int PRESC     = 250,
    parameter int RAMP_STEP = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [CW-1:0]                        period,
    input  logic [1:0]                           speed,
    input  logic                                 duty_wr,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] duty_sel,
    input  logic [CW-1:0]                        duty_val,
    output logic [CH-1:0]                        pwm_out,
    output logic                                 period_start,
    output logic [1:0]                           led_speed
);

    localparam int SW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    if (CH < 1 || CH > 16 || CW < 1 || PRESC < 1 || RAMP_STEP < 1) begin : g_param_err
        $error("pwm_multi: parameter out of range");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_act_q, period_act_d;
    logic          en_prev_q, en_prev_d;
    logic [CW-1:0] shadow_q [CH];
    logic [CW-1:0] shadow_d [CH];
    logic [CW-1:0] active_q [CH];
    logic [CW-1:0] active_d [CH];
    logic [CW-1:0] eff [CH];
    logic [CH-1:0] pwm_q, pwm_d;
    logic          period_start_q, period_start_d;
    logic [1:0]    led_speed_q, led_speed_d;

    logic          en_rise;
    logic          tick;
    logic          boundary;
    logic [CW-1:0] per_use;

`ifdef PWM_RAMP_EN
    localparam logic [CW-1:0] STEP = CW'(RAMP_STEP);

    function automatic logic [CW-1:0] ramp_to(input logic [CW-1:0] cur, input logic [CW-1:0] tgt);
        logic [CW-1:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return (diff > STEP) ? cur + STEP : tgt;
        end else begin
            diff = cur - tgt;
            return (diff > STEP) ? cur - STEP : tgt;
        end
    endfunction
`endif

    always_comb begin
        en_prev_d = en;
        en_rise   = en & ~en_prev_q;
        // A fresh enable uses the live period input so counting starts in the same clk.
        per_use   = en_rise ? period : period_act_q;
        tick      = en && (presc_q == PRESC_LAST);
        boundary  = tick && (per_use != '0) && (cnt_q == per_use - CW'(1));

        if (!en || tick) presc_d = '0;
        else             presc_d = presc_q + PW'(1);

        if (!en || per_use == '0 || boundary) cnt_d = '0;
        else if (tick)                        cnt_d = cnt_q + CW'(1);
        else                                  cnt_d = cnt_q;

        period_act_d   = (en_rise || boundary) ? period : period_act_q;
        period_start_d = boundary;
        led_speed_d    = boundary ? speed : led_speed_q;

        for (int i = 0; i < CH; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
            if (boundary) begin
`ifdef PWM_RAMP_EN
                active_d[i] = ramp_to(active_q[i], shadow_q[i]);
`else
                active_d[i] = shadow_q[i];
`endif
            end
            // Out-of-range selects match no channel and are dropped.
            if (duty_wr && duty_sel == SW'(i)) shadow_d[i] = duty_val;

            case (led_speed_q)
                2'b11:   eff[i] = active_q[i];
                2'b10:   eff[i] = active_q[i] >> 1;
                2'b01:   eff[i] = active_q[i] >> 2;
                default: eff[i] = '0;
            endcase
            pwm_d[i] = en && (per_use != '0) && (cnt_q < eff[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            period_act_q   <= '0;
            en_prev_q      <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            led_speed_q    <= 2'b00;
            for (int i = 0; i < CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            period_act_q   <= period_act_d;
            en_prev_q      <= en_prev_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            led_speed_q    <= led_speed_d;
            for (int i = 0; i < CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign led_speed    = led_speed_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: two instances (prescale 1 and 3) checked every clk against a
// clk-position model, plus directed period-level high-time checks on the prescale-1 instance.
module tb_pwm_multi;

    localparam int CH = 3;
    localparam int CW = 12;
    localparam int RS = 8;
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic [CW-1:0] period;
    logic [1:0]    speed;
    logic          duty_wr;
    logic [SW-1:0] duty_sel;
    logic [CW-1:0] duty_val;
    logic [CH-1:0] pwm_a, pwm_b;
    logic          ps_a, ps_b;
    logic [1:0]    led_a, led_b;

    int checks = 0;
    int errors = 0;
    int hi_cnt [CH];
    int n_wait;
    int per_now;

    pwm_multi #(.CH(CH), .CW(CW), .PRESC(1), .RAMP_STEP(RS)) u_dut_p1 (
        .clk(clk), .rst(rst), .en(en), .period(period), .speed(speed),
        .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_val(duty_val),
        .pwm_out(pwm_a), .period_start(ps_a), .led_speed(led_a));

    pwm_multi #(.CH(CH), .CW(CW), .PRESC(3), .RAMP_STEP(RS)) u_dut_p3 (
        .clk(clk), .rst(rst), .en(en), .period(period), .speed(speed),
        .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_val(duty_val),
        .pwm_out(pwm_b), .period_start(ps_b), .led_speed(led_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50) $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Model: position in clks within the current period; cnt = pos / prescale.
    int            m_pos [2];
    int            m_per [2];
    logic          m_enp [2];
    int            m_sh  [2][CH];
    int            m_act [2][CH];
    int            m_led [2];
    logic [CH-1:0] m_pwm [2];
    logic          m_ps  [2];

    task automatic model_step(input int k, input int p);
        int   per_use, cnt, eff;
        logic bnd;
        if (rst) begin
            m_pos[k] = 0; m_per[k] = 0; m_enp[k] = 1'b0; m_led[k] = 0;
            m_pwm[k] = '0; m_ps[k] = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_sh[k][c] = 0; m_act[k][c] = 0;
            end
            return;
        end
        per_use = (en && !m_enp[k]) ? int'(period) : m_per[k];
        cnt = m_pos[k] / p;
        for (int c = 0; c < CH; c++) begin
            eff = (m_led[k] == 0) ? 0 : (m_act[k][c] >> (3 - m_led[k]));
            m_pwm[k][c] = en && per_use > 0 && cnt < eff;
        end
        bnd = en && per_use > 0 && m_pos[k] == p * per_use - 1;
        m_ps[k] = bnd;
        if (!en || per_use == 0 || bnd) m_pos[k] = 0;
        else                            m_pos[k] = m_pos[k] + 1;
        if (en && !m_enp[k]) m_per[k] = int'(period);
        if (bnd) begin
            m_per[k] = int'(period);
            m_led[k] = int'(speed);
            for (int c = 0; c < CH; c++) begin
`ifdef PWM_RAMP_EN
                int d;
                d = m_sh[k][c] - m_act[k][c];
                if (d > RS)       m_act[k][c] = m_act[k][c] + RS;
                else if (d < -RS) m_act[k][c] = m_act[k][c] - RS;
                else              m_act[k][c] = m_sh[k][c];
`else
                m_act[k][c] = m_sh[k][c];
`endif
            end
        end
        if (duty_wr && int'(duty_sel) < CH) m_sh[k][int'(duty_sel)] = int'(duty_val);
        m_enp[k] = en;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0, 1);
            model_step(1, 3);
            #1;
            chk("pwm_p1", 32'(pwm_a), 32'(m_pwm[0]));
            chk("pstart_p1", 32'(ps_a), 32'(m_ps[0]));
            chk("led_p1", 32'(led_a), 32'(m_led[0]));
            chk("pwm_p3", 32'(pwm_b), 32'(m_pwm[1]));
            chk("pstart_p3", 32'(ps_b), 32'(m_ps[1]));
            chk("led_p3", 32'(led_b), 32'(m_led[1]));
        end
    end

    task automatic write_duty(input int ch, input int v);
        duty_wr  = 1'b1;
        duty_sel = SW'(ch);
        duty_val = CW'(v);
        @(negedge clk);
        duty_wr  = 1'b0;
    endtask

    // Returns clks until the prescale-1 instance shows period_start, -1 on timeout.
    task automatic wait_pstart(output int n);
        n = -1;
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk);
            if (ps_a) begin
                n = k;
                return;
            end
        end
    endtask

    // Call at a period_start negedge; counts high clks per channel over n clks and
    // ends on the next period_start negedge. Optional speed change and two duty writes.
    task automatic count_period(input int n, input int sp_at, input logic [1:0] sp_v,
                                input int wa_at, input int wa_ch, input int wa_v,
                                input int wb_at, input int wb_ch, input int wb_v);
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (pwm_a[c]) hi_cnt[c]++;
            duty_wr = 1'b0;
            if (i == sp_at) speed = sp_v;
            if (i == wa_at) begin
                duty_wr = 1'b1; duty_sel = SW'(wa_ch); duty_val = CW'(wa_v);
            end
            if (i == wb_at) begin
                duty_wr = 1'b1; duty_sel = SW'(wb_ch); duty_val = CW'(wb_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; period = '0; speed = 2'b00;
        duty_wr = 1'b0; duty_sel = '0; duty_val = '0;
        repeat (3) @(negedge clk);
        chk("reset_pwm", 32'(pwm_a), 0);
        chk("reset_led", 32'(led_a), 0);
        chk("reset_pstart", 32'(ps_a), 0);
        rst = 1'b0;

`ifdef PWM_RAMP_EN
        write_duty(0, 30);
        period = CW'(64); speed = 2'b11; en = 1'b1;
        wait_pstart(n_wait);
        chk("ramp_first_boundary", n_wait, 64);
        count_period(64, -1, 2'b11, -1, 0, 0, -1, 0, 0);
        chk("ramp_step1", hi_cnt[0], 8);
        count_period(64, -1, 2'b11, -1, 0, 0, -1, 0, 0);
        chk("ramp_step2", hi_cnt[0], 16);
        count_period(64, -1, 2'b11, -1, 0, 0, -1, 0, 0);
        chk("ramp_step3", hi_cnt[0], 24);
        count_period(64, -1, 2'b11, -1, 0, 0, -1, 0, 0);
        chk("ramp_step4", hi_cnt[0], 30);
        per_now = 64;
`else
        write_duty(0, 3);
        write_duty(2, 20);
        period = CW'(10); speed = 2'b11; en = 1'b1;
        wait_pstart(n_wait);
        chk("first_boundary", n_wait, 10);
        count_period(10, -1, 2'b11, -1, 0, 0, -1, 0, 0);
        chk("p10_ch0_high", hi_cnt[0], 3);
        chk("p10_ch1_low", hi_cnt[1], 0);
        chk("p10_ch2_high", hi_cnt[2], 10);
        chk("p10_pstart_spacing", 32'(ps_a), 1);

        period = CW'(16);
        count_period(10, -1, 2'b11, 1, 0, 8, -1, 0, 0);
        chk("no_midperiod_duty", hi_cnt[0], 3);
        count_period(16, 5, 2'b01, -1, 0, 0, -1, 0, 0);
        chk("speed_mid_ch0", hi_cnt[0], 8);
        chk("duty0_const_low", hi_cnt[1], 0);
        chk("duty20_const_high", hi_cnt[2], 16);
        chk("led_at_boundary", 32'(led_a), 1);
        count_period(16, 3, 2'b11, -1, 0, 0, -1, 0, 0);
        chk("quarter_ch0", hi_cnt[0], 2);
        chk("quarter_ch2", hi_cnt[2], 5);

        count_period(16, -1, 2'b11, 2, 3, 7, 6, 1, 2);
        chk("full_ch0", hi_cnt[0], 8);
        count_period(16, -1, 2'b11, 4, 0, 9, 9, 0, 6);
        chk("ch1_after_write", hi_cnt[1], 2);
        chk("wrap_no_glitch_ch2", hi_cnt[2], 16);
        count_period(16, -1, 2'b11, 15, 1, 5, -1, 0, 0);
        chk("last_write_wins", hi_cnt[0], 6);
        count_period(16, -1, 2'b11, -1, 0, 0, -1, 0, 0);
        chk("boundary_write_old", hi_cnt[1], 2);
        count_period(16, -1, 2'b11, -1, 0, 0, -1, 0, 0);
        chk("boundary_write_new", hi_cnt[1], 5);
        per_now = 16;
`endif

        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_fall_pwm", 32'(pwm_a), 0);
        chk("en_fall_pstart", 32'(ps_a), 0);
        en = 1'b1;
        wait_pstart(n_wait);
        chk("en_rise_restart", n_wait, per_now);

        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_pwm", 32'(pwm_a), 0);
        chk("rst_mid_led", 32'(led_a), 0);
        chk("rst_mid_pstart", 32'(ps_a), 0);
        rst = 1'b0;
        wait_pstart(n_wait);
        chk("rst_restart_cnt0", n_wait, per_now);
        count_period(per_now, -1, 2'b11, -1, 0, 0, -1, 0, 0);
        chk("rst_duties_cleared", hi_cnt[0] + hi_cnt[1] + hi_cnt[2], 0);
        chk("rst_led_resampled", 32'(led_a), 3);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 CH, 4, number of independent PWM channels (1..16).
REQ-002 CW, 12, width of period counter and duty values.
REQ-003 PRESC, 250, clk cycles per PWM tick (>=1; 1 = tick every clk).
REQ-004 RAMP_STEP, 8, max duty change per period when ramping is compiled in.
REQ-005 clk  input  1  system clock, all logic on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  run enable; 0 holds counters cleared and outputs low.
REQ-008 period  input  CW  PWM period in ticks; sampled at period boundary.
REQ-009 speed  input  2  speed level; 11 full, 10 half, 01 quarter, 00 stop.
REQ-010 duty_wr  input  1  one-clk strobe writing duty_val to shadow of channel duty_sel.
REQ-011 duty_sel  input  max(1,$clog2(CH))  channel index for duty_wr; indices >= CH ignored.
REQ-012 duty_val  input  CW  requested duty in ticks.
REQ-013 pwm_out  output  CH  registered PWM outputs.
REQ-014 period_start  output  1  one-clk pulse at each period boundary.
REQ-015 led_speed  output  2  speed level currently applied (registered).

Function
REQ-016 Prescaler counts 0..PRESC-1 while en=1; tick asserted in the clk where prescaler = PRESC-1, prescaler then wraps to 0.
REQ-017 Period counter cnt (CW bits) increments on tick; on tick with cnt = period_act-1 it wraps to 0 (the boundary).
REQ-018 period_act loads from period at each boundary and when en rises; period_act = 0 holds cnt at 0, all pwm_out low, no boundaries.
REQ-019 Boundary clk: period_start = 1 for exactly that clk; speed sampled into led_speed; active duties updated per REQ-022.
REQ-020 Effective duty eff[i] = active[i] >> s, s = 0/1/2 for led_speed 11/10/01; led_speed 00 forces all pwm_out low.
REQ-021 pwm_out[i] = 1 iff cnt < eff[i], registered: output reflects cnt one clk later; eff >= period_act gives constant high, eff = 0 constant low.
REQ-022 Shadow duties written on duty_wr regardless of en; active[i] loads shadow[i] only at boundaries (glitch-free, no mid-period change).
REQ-023 duty_wr coinciding with a boundary clk: active loads the pre-write shadow; the new value applies at the next boundary.
REQ-024 Multiple writes to one channel within a period: last write wins.
REQ-025 en falling: prescaler, cnt, pwm_out cleared next clk; shadow and active retained; period_start not asserted.

Reset
REQ-026 rst (sync, clk edge) clears prescaler, cnt, period_act, all shadow and active duties, pwm_out = 0, period_start = 0, led_speed = 00.
REQ-027 rst asserted mid-period takes priority over all other inputs in that clk; operation resumes from cnt = 0 after rst deasserts with en = 1.

Configuration
REQ-028 Macro PWM_RAMP_EN defined: at each boundary active[i] moves toward shadow[i] by min(RAMP_STEP, |shadow-active|), soft start/stop.
REQ-029 PWM_RAMP_EN undefined: active[i] = shadow[i] at each boundary; ramp logic and RAMP_STEP unused.

Verification
REQ-030 PRESC=1, period=10, speed=11, duty ch0=3 -> after first boundary, pwm_out[0] high 3 clk, low 7 clk, period_start every 10 clk.
REQ-031 speed 11->01 mid-period, duty=8, period=16 -> change takes effect only at next boundary; high time 8 then 2 ticks; led_speed updates same clk.
REQ-032 duty=0 and duty=20 with period=16 -> channel constant low and constant high respectively, no glitch at wrap.
REQ-033 duty_wr ch1=5 on boundary clk (old shadow 2) -> next period high 2 ticks, following period 5 ticks.
REQ-034 rst pulse at cnt=7 -> next clk all outputs 0, led_speed 00, duties 0; en=1 restarts from cnt=0.
REQ-035 PWM_RAMP_EN, RAMP_STEP=8, duty 0->30, period=64 -> active 8,16,24,30 over four successive boundaries.
